// File: rtl/one_bit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : one_bit_pkg
// Purpose  : Shared constants for the one_bit logic unit: synchronizer depth
//            default and legal range, and the output reset value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package one_bit_pkg;

  localparam int   SYNC_STAGES_DEFAULT = 2;
  localparam int   SYNC_STAGES_MIN     = 2;
  localparam int   SYNC_STAGES_MAX     = 4;
  localparam logic OUT_RST             = 1'b0;

endpackage : one_bit_pkg
`default_nettype wire

// File: rtl/one_bit_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : one_bit_sync
// Purpose  : Generic 1-bit, STAGES-deep flop-chain synchronizer. Every flop
//            clears to 0 on reset.
// Ports    : clk   - destination clock
//            rst_n - asynchronous active-low reset
//            d     - input, may be asynchronous to clk
//            q     - synchronized output (last flop of the chain)
// Revision : 1.0 - initial release
// ============================================================================
module one_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Separate branch for a single stage keeps the shift slice legal; the top
  // rejects depths below 2, but this module stays usable on its own.
  if (STAGES == 1) begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_chain <= '0;
      else        r_chain <= d;
    end
  end else begin : g_chain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_chain <= '0;
      else        r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule : one_bit_sync
`default_nettype wire

// File: rtl/one_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : one_bit
// Purpose  : Single-bit clocked logic unit. Registers AND, OR, XOR and NOR of
//            two 1-bit operands. With ONE_BIT_SYNC_EN defined, each operand
//            first passes through a SYNC_STAGES-deep synchronizer (latency
//            SYNC_STAGES+1 edges); otherwise latency is 1 edge.
// Macro    : ONE_BIT_SYNC_EN - compile in the input synchronizers
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset, clears every flop to 0
//            a, b  - operands, may be asynchronous to clk
//            e     - registered a AND b
//            f     - registered a OR b
//            g     - registered a XOR b
//            h     - registered NOR(a, b)
// Revision : 1.0 - initial release
// ============================================================================
module one_bit
  import one_bit_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic e,
  output logic f,
  output logic g,
  output logic h
);

`ifdef ONE_BIT_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  // Depth only matters when the synchronizer exists.
  if (SYNC_ON && ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX))) begin : g_depth_check
    $error("one_bit: SYNC_STAGES=%0d outside legal range %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  logic w_a_s;
  logic w_b_s;

`ifdef ONE_BIT_SYNC_EN
  one_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a),
    .q     (w_a_s)
  );

  one_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (b),
    .q     (w_b_s)
  );
`else
  assign w_a_s = a;
  assign w_b_s = b;
`endif

  logic w_and;
  logic w_or;
  logic w_xor;
  logic w_nor;

  assign w_and = w_a_s & w_b_s;
  assign w_or  = w_a_s | w_b_s;
  assign w_xor = w_a_s ^ w_b_s;
  assign w_nor = ~(w_a_s | w_b_s);

  logic r_e;
  logic r_f;
  logic r_g;
  logic r_h;

  // NOR output also resets to 0, so f == ~h does not hold while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= OUT_RST;
      r_f <= OUT_RST;
      r_g <= OUT_RST;
      r_h <= OUT_RST;
    end else begin
      r_e <= w_and;
      r_f <= w_or;
      r_g <= w_xor;
      r_h <= w_nor;
    end
  end

  assign e = r_e;
  assign f = r_f;
  assign g = r_g;
  assign h = r_h;

endmodule : one_bit
`default_nettype wire

// File: tb/tb_one_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_one_bit
// Purpose  : Self-checking bench for one_bit: reset behaviour, truth-table
//            sweep, latency, asynchronous reset mid-run, asynchronous toggling
//            and random stimulus against a delay-line reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_one_bit;

  localparam int SYNC_STAGES = 2;
`ifdef ONE_BIT_SYNC_EN
  localparam int LAT = SYNC_STAGES + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic e;
  logic f;
  logic g;
  logic h;

  int checks = 0;
  int errors = 0;

  one_bit #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .e     (e),
    .f     (f),
    .g     (g),
    .h     (h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: efgh=%b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: outputs after an edge are a function of how many operands were
  // high LAT sampling edges earlier (zeros before reset release).
  function automatic logic [3:0] ref_efgh(input logic [1:0] ab);
    int ones;
    ones = int'(ab[1]) + int'(ab[0]);
    return {ones == 2, ones >= 1, ones == 1, ones == 0};
  endfunction

  logic [1:0] hist_q[$];
  logic [3:0] exp_out = 4'b0000;
  int         edges   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q.delete();
      for (int i = 0; i < LAT - 1; i++) hist_q.push_back(2'b00);
      exp_out = 4'b0000;
      edges   = 0;
    end else begin
      hist_q.push_back({a, b});
      exp_out = ref_efgh(hist_q.pop_front());
      edges++;
    end
  end

  // Continuous comparison plus invariants, away from the active edge.
  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("model", {e, f, g, h}, exp_out);
      if (rst_n && edges >= 1) begin
        checks++;
        if ((f !== ~h) || (g !== (f & ~e)) || ((int'(e) + int'(g) + int'(h)) > 1)) begin
          errors++;
          $display("FAIL invariant at %0t: efgh=%b", $time, {e, f, g, h});
        end
      end
    end
  end

  typedef struct {
    logic       a;
    logic       b;
    logic [3:0] efgh;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;

    vecs[0] = '{a: 1'b0, b: 1'b0, efgh: 4'b0001};
    vecs[1] = '{a: 1'b1, b: 1'b0, efgh: 4'b0110};
    vecs[2] = '{a: 1'b0, b: 1'b1, efgh: 4'b0110};
    vecs[3] = '{a: 1'b1, b: 1'b1, efgh: 4'b1100};

    // Reset held: outputs 0 regardless of operands, h included.
    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("rst_hold_11", {e, f, g, h}, 4'b0000);
    a = 1'b0;
    b = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("rst_hold_00", {e, f, g, h}, 4'b0000);

    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Truth-table sweep, each pair held 10 cycles.
    foreach (vecs[i]) begin
      @(negedge clk);
      a = vecs[i].a;
      b = vecs[i].b;
      repeat (10) @(posedge clk);
      #1 check($sformatf("sweep_%b%b", vecs[i].a, vecs[i].b), {e, f, g, h}, vecs[i].efgh);
    end

    // Latency: 00 -> 11, e must rise exactly on edge LAT.
    @(negedge clk);
    a = 1'b0;
    b = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    hit = 0;
    for (int n = 1; n <= LAT + 3; n++) begin
      @(posedge clk);
      #1 if (e === 1'b1 && hit == 0) hit = n;
    end
    check("latency_edge", 4'(hit), 4'(LAT));

    // Asynchronous reset pulse mid-cycle while e is 1.
    @(posedge clk);
    #1 check("pre_pulse", {e, f, g, h}, 4'b1100);
    #2 rst_n = 1'b0;
    #1 check("async_clear", {e, f, g, h}, 4'b0000);
    #2 rst_n = 1'b1;
    hit = 0;
    for (int n = 1; n <= LAT + 3; n++) begin
      @(posedge clk);
      #1 if (e === 1'b1 && hit == 0) hit = n;
    end
    check("post_rst_latency", 4'(hit), 4'(LAT));

    // Asynchronous toggling: a every 50 ns, b every 100 ns, for 1000 ns.
    @(negedge clk);
    a = 1'b0;
    b = 1'b0;
    fork
      begin repeat (20) #50  a = ~a; end
      begin repeat (10) #100 b = ~b; end
    join

    // Random operands changed at random points between clock edges.
    repeat (300) begin
      @(negedge clk);
      #($urandom_range(1, 3));
      a = 1'($urandom);
      b = 1'($urandom);
    end

    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_one_bit
`default_nettype wire
